// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a single shared integer ALU.
// One transaction in flight: IDLE (grant) -> EXEC (compute) -> RESP (hold result).
module alu_arbiter #(
   parameter int DW  = 32,
   parameter int OPW = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           req0,
   input  logic [OPW-1:0] op0,
   input  logic [DW-1:0]  a0,
   input  logic [DW-1:0]  b0,
   output logic           gnt0,
   input  logic           req1,
   input  logic [OPW-1:0] op1,
   input  logic [DW-1:0]  a1,
   input  logic [DW-1:0]  b1,
   output logic           gnt1,
   output logic           res_valid,
   output logic           res_id,
   output logic [DW-1:0]  res,
   input  logic           res_ready,
   output logic           busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

   state_t         state, state_nx;
   logic           last_id;
   logic           lat_id;
   logic [OPW-1:0] lat_op;
   logic [DW-1:0]  lat_a, lat_b;
   logic [DW-1:0]  alu_y;

   // Handshake: a result transfers on any rising edge where res_valid && res_ready;
   // res/res_id/res_valid stay stable until then, and grants only assert in IDLE.
   always_comb begin
      gnt0     = 1'b0;
      gnt1     = 1'b0;
      state_nx = state;
      case (state)
         IDLE: begin
            if (req0 && (!req1 || last_id)) gnt0 = 1'b1;
            else if (req1)                  gnt1 = 1'b1;
            if (gnt0 || gnt1) state_nx = EXEC;
         end
         EXEC:    state_nx = RESP;
         RESP:    if (res_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      alu_y = '0;
      case (lat_op)
         4'd1:    alu_y = lat_a | lat_b;
         4'd2:    alu_y = lat_a + lat_b;
         4'd3:    alu_y = lat_a - lat_b;
         4'd4:    alu_y = lat_b << 16;
         default: alu_y = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // last_id resets to 1 so requester 0 wins the first contested grant.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_id   <= 1'b1;
         lat_id    <= 1'b0;
         lat_op    <= '0;
         lat_a     <= '0;
         lat_b     <= '0;
         res       <= '0;
         res_id    <= 1'b0;
         res_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (gnt0 || gnt1) begin
                  lat_op  <= gnt1 ? op1 : op0;
                  lat_a   <= gnt1 ? a1  : a0;
                  lat_b   <= gnt1 ? b1  : b0;
                  lat_id  <= gnt1;
                  last_id <= gnt1;
               end
            end
            EXEC: begin
               res       <= alu_y;
               res_id    <= lat_id;
               res_valid <= 1'b1;
            end
            RESP: begin
               if (res_ready) res_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: expected {res_id,res} pushed at stimulus time,
// popped and compared by a monitor whenever a result is accepted.
module tb_alu_arbiter;
   localparam int DW  = 32;
   localparam int OPW = 4;

   logic           clk = 1'b0;
   logic           reset;
   logic           req0, req1;
   logic [OPW-1:0] op0, op1;
   logic [DW-1:0]  a0, b0, a1, b1;
   logic           gnt0, gnt1;
   logic           res_valid, res_id;
   logic [DW-1:0]  res;
   logic           res_ready;
   logic           busy;

   logic [DW:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   alu_arbiter #(.DW(DW), .OPW(OPW)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .op0(op0), .a0(a0), .b0(b0), .gnt0(gnt0),
      .req1(req1), .op1(op1), .a1(a1), .b1(b1), .gnt1(gnt1),
      .res_valid(res_valid), .res_id(res_id), .res(res),
      .res_ready(res_ready), .busy(busy)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // monitor: scoreboard pop on every accepted result
   always @(negedge clk) begin
      if (!reset && res_valid && res_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_response: got id=%0d res=%h expected none", res_id, res);
         end else begin
            logic [DW:0] e;
            e = exp_q.pop_front();
            if ({res_id, res} !== e) begin
               errors++;
               $display("FAIL response: got id=%0d res=%h expected id=%0d res=%h",
                        res_id, res, e[DW], e[DW-1:0]);
            end
         end
      end
   end

   // monitor: grants are one-hot and only while idle
   always @(negedge clk) begin
      if (!reset && (gnt0 || gnt1)) begin
         checks++;
         if ((gnt0 && gnt1) || busy) begin
            errors++;
            $display("FAIL grant_legal: got gnt0=%0d gnt1=%0d busy=%0d expected one grant in idle",
                     gnt0, gnt1, busy);
         end
      end
   end

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic wait_gnt(output int id);
      bit seen = 0;
      id = -1;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge clk);
         if (gnt0 || gnt1) begin
            seen = 1;
            id = gnt1 ? 1 : 0;
         end
      end
      if (!seen) begin
         errors++;
         checks++;
         $display("FAIL grant_timeout: got no grant expected grant");
      end
   endtask

   task automatic wait_valid();
      bit seen = 0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge clk);
         if (res_valid) seen = 1;
      end
      if (!seen) begin
         errors++;
         checks++;
         $display("FAIL valid_timeout: got res_valid=0 expected 1");
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
      chk("drain", 64'(exp_q.size()), 64'd0);
      step();
   endtask

   task automatic run_one(input int id, input logic [OPW-1:0] op, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [DW-1:0] exp);
      int g;
      exp_q.push_back({id[0], exp});
      if (id == 0) begin req0 = 1; op0 = op; a0 = a; b0 = b; end
      else         begin req1 = 1; op1 = op; a1 = a; b1 = b; end
      wait_gnt(g);
      chk("run_one_grant", 64'(g), 64'(id));
      step();
      req0 = 0;
      req1 = 0;
   endtask

   initial begin
      int g;
      int exp_order[4];
      reset = 1; req0 = 0; req1 = 0; op0 = 0; op1 = 0;
      a0 = 0; b0 = 0; a1 = 0; b1 = 0; res_ready = 0;
      exp_order = '{0, 1, 0, 1};

      // reset values
      repeat (2) @(negedge clk);
      chk("reset_res_valid", 64'(res_valid), 64'd0);
      chk("reset_res", 64'(res), 64'd0);
      chk("reset_res_id", 64'(res_id), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      step();
      reset = 0;
      step();

      // single add, latency check
      req0 = 1; op0 = 4'd2; a0 = 32'h5; b0 = 32'h3; res_ready = 1;
      exp_q.push_back({1'b0, 32'h0000_0008});
      @(negedge clk);
      chk("t1_gnt0", 64'(gnt0), 64'd1);
      step();
      req0 = 0;
      @(negedge clk);
      chk("t1_busy_exec", 64'(busy), 64'd1);
      chk("t1_valid_early", 64'(res_valid), 64'd0);
      @(negedge clk);
      chk("t1_valid", 64'(res_valid), 64'd1);
      chk("t1_res", 64'(res), 64'h8);
      chk("t1_res_id", 64'(res_id), 64'd0);
      @(negedge clk);
      chk("t1_busy_done", 64'(busy), 64'd0);
      step();
      drain();

      // fairness with both requesting continuously
      do_reset();
      req0 = 1; op0 = 4'd1; a0 = 32'hF0F0_0000; b0 = 32'h0000_FFFF;
      req1 = 1; op1 = 4'd3; a1 = 32'h0;         b1 = 32'h1;
      for (int i = 0; i < 4; i++)
         exp_q.push_back(exp_order[i] == 0 ? {1'b0, 32'hF0F0_FFFF} : {1'b1, 32'hFFFF_FFFF});
      for (int i = 0; i < 4; i++) begin
         wait_gnt(g);
         chk("fair_order", 64'(g), 64'(exp_order[i]));
      end
      step();
      req0 = 0; req1 = 0;
      drain();

      // stall in RESP with req0 pending
      res_ready = 0;
      exp_q.push_back({1'b1, 32'h1234_0000});
      req1 = 1; op1 = 4'd4; a1 = 32'hDEAD_BEEF; b1 = 32'h0000_1234;
      wait_gnt(g);
      chk("stall_gnt", 64'(g), 64'd1);
      step();
      req1 = 0;
      exp_q.push_back({1'b0, 32'h0000_0003});
      req0 = 1; op0 = 4'd1; a0 = 32'h1; b0 = 32'h2;
      wait_valid();
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         chk("stall_res", 64'(res), 64'h1234_0000);
         chk("stall_id", 64'(res_id), 64'd1);
         chk("stall_valid", 64'(res_valid), 64'd1);
         chk("stall_no_gnt", 64'({gnt0, gnt1}), 64'd0);
      end
      step();
      res_ready = 1;
      @(negedge clk);
      @(negedge clk);
      chk("post_accept_gnt0", 64'(gnt0), 64'd1);
      step();
      req0 = 0;
      drain();

      // wrap, shifted B with high bits, illegal op
      run_one(0, 4'd2, 32'hFFFF_FFFF, 32'h1, 32'h0);
      drain();
      run_one(1, 4'd4, 32'h0, 32'hABCD_1234, 32'h1234_0000);
      drain();
      run_one(1, 4'd7, 32'h1234, 32'h5678, 32'h0);
      drain();

      // asynchronous reset during EXEC drops the transaction
      req0 = 1; op0 = 4'd1; a0 = 32'h11; b0 = 32'h22;
      wait_gnt(g);
      chk("rst_pre_gnt", 64'(g), 64'd0);
      step();
      req0 = 0;
      #2 reset = 1;
      #1;
      chk("rst_async_busy", 64'(busy), 64'd0);
      chk("rst_async_valid", 64'(res_valid), 64'd0);
      chk("rst_async_gnt", 64'({gnt0, gnt1}), 64'd0);
      step();
      step();
      reset = 0;
      step();
      exp_q.push_back({1'b0, 32'h0000_001E});
      req0 = 1; op0 = 4'd2; a0 = 32'd10; b0 = 32'd20;
      req1 = 1; op1 = 4'd2; a1 = 32'd1;  b1 = 32'd1;
      wait_gnt(g);
      chk("rst_first_contest", 64'(g), 64'd0);
      step();
      req0 = 0; req1 = 0;
      drain();

      // req0 pulse during RESP must not create a transaction
      res_ready = 0;
      run_one(1, 4'd1, 32'h00FF_0000, 32'h0000_FF00, 32'h00FF_FF00);
      wait_valid();
      step();
      req0 = 1; op0 = 4'd2; a0 = 32'h7; b0 = 32'h7;
      @(negedge clk);
      chk("pulse_no_gnt", 64'({gnt0, gnt1}), 64'd0);
      step();
      req0 = 0;
      res_ready = 1;
      drain();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("pulse_quiet", 64'({gnt0, gnt1, res_valid, busy}), 64'd0);
      end

      chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
